if_fetch_unit: RTL

Instruction fetch front end that produces the `pc` / `instruction` pair consumed by the IF/ID pipeline register. It owns the program counter and issues single-outstanding requests to a variable-latency instruction memory. It holds each fetched word until the pipeline accepts it (`freeze` low) and redirects on `branch_taken` from EX. Cycles with no instruction available are presented as NOP bubbles.

---
 rtl/if_fetch_unit_pkg.sv | 14 +
 rtl/if_fetch_unit.sv | 98 +++++++++
 2 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the instruction fetch front end: state encodings,
// the default bubble word and the PC step.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INC      = 32'd4;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps one request outstanding to a
// variable-latency instruction memory and presents pc/instruction to IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        inst_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcReg_q, pcReg_d;
  logic [31:0]  reqAddr_q, reqAddr_d;
  logic [31:0]  instBuf_q, instBuf_d;
  logic [31:0]  pcPlus4;

  assign pcPlus4 = pcReg_q + PC_INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REQ;
      pcReg_q   <= RESET_PC;
      reqAddr_q <= RESET_PC;
      instBuf_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      pcReg_q   <= pcReg_d;
      reqAddr_q <= reqAddr_d;
      instBuf_q <= instBuf_d;
    end
  end

  // A request can never be withdrawn, so a branch that misses the completion
  // cycle must drain the stale response in DROP before re-issuing.
  always_comb begin
    state_d   = state_q;
    pcReg_d   = pcReg_q;
    reqAddr_d = reqAddr_q;
    instBuf_d = instBuf_q;
    unique case (state_q)
      REQ: begin
        if (branch_taken) begin
          pcReg_d = branch_address;
          if (mem_ready) begin
            reqAddr_d = branch_address;
          end else begin
            state_d = DROP;
          end
        end else if (mem_ready) begin
          instBuf_d = mem_rdata;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pcReg_d   = branch_address;
          reqAddr_d = branch_address;
          state_d   = REQ;
        end else if (!freeze) begin
          pcReg_d   = pcPlus4;
          reqAddr_d = pcPlus4;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (branch_taken) begin
          pcReg_d = branch_address;
        end
        if (mem_ready) begin
          reqAddr_d = branch_taken ? branch_address : pcReg_q;
          state_d   = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  assign mem_req     = (state_q == REQ) || (state_q == DROP);
  assign mem_addr    = reqAddr_q;
  assign inst_valid  = (state_q == HOLD);
  assign pc          = inst_valid ? pcPlus4 : 32'h0000_0000;
  assign instruction = inst_valid ? instBuf_q : NOP_INSTR;

endmodule
